// File: rtl/stream_split.sv
// stream_split: fans one valid/ready input stream out to two independent
// output streams. Each accepted beat {left, right} is written to a per-side
// FIFO in the same cycle; the two sides then drain independently, so one
// consumer may run up to a FIFO depth ahead of the other before input stalls.
//
// Ports:
//   clk, reset                     sole clock; synchronous active-high reset
//   i_valid/i_ready/i_data         input stream, i_data = {left, right}
//   o_left_valid/ready/data        left output stream (LEFT_WIDTH)
//   o_right_valid/ready/data       right output stream (RIGHT_WIDTH)
//
// Build option: define STREAM_SPLIT_OUTREG_EN to insert a 2-entry skid
// buffer between each FIFO head and its output port (registered outputs,
// 2-cycle latency, per-side capacity DEPTH+2).

module stream_split_side #(
  parameter int unsigned W       = 8,
  parameter int unsigned ADDR_SZ = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o_data
);
  localparam int unsigned DEPTH = 1 << ADDR_SZ;
  localparam logic [ADDR_SZ:0] FULL_CNT = (ADDR_SZ + 1)'(DEPTH);

  logic [W-1:0]       mem [DEPTH];
  logic [ADDR_SZ-1:0] wptr, rptr;
  logic [ADDR_SZ:0]   cnt;
  logic               rd_en;
  logic               head_v;
  logic [W-1:0]       head_d;

  assign full   = (cnt == FULL_CNT);
  // Head is masked during reset so nothing can be popped while state clears.
  assign head_v = (cnt != '0) && !reset;
  assign head_d = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push)  wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({push, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wptr] <= wdata;
  end

`ifdef STREAM_SPLIT_OUTREG_EN
  // hd_* is the registered output slot, sk_* catches one extra beat. The FIFO
  // is read only when the skid slot is free, so o_ready never reaches rd_en.
  logic         hd_v, sk_v;
  logic [W-1:0] hd_d, sk_d;
  logic         pop;

  assign rd_en = head_v && !sk_v;
  assign pop   = hd_v && o_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      hd_v <= 1'b0;
      hd_d <= '0;
      sk_v <= 1'b0;
      sk_d <= '0;
    end else if (pop) begin
      if (sk_v) begin
        hd_v <= 1'b1;
        hd_d <= sk_d;
        sk_v <= 1'b0;
        sk_d <= '0;
      end else if (rd_en) begin
        hd_v <= 1'b1;
        hd_d <= head_d;
      end else begin
        hd_v <= 1'b0;
        hd_d <= '0;
      end
    end else if (rd_en) begin
      if (!hd_v) begin
        hd_v <= 1'b1;
        hd_d <= head_d;
      end else begin
        sk_v <= 1'b1;
        sk_d <= head_d;
      end
    end
  end

  assign o_valid = hd_v;
  assign o_data  = hd_d;
`else
  assign rd_en   = head_v && o_ready;
  assign o_valid = head_v;
  assign o_data  = head_v ? head_d : '0;
`endif
endmodule

module stream_split #(
  parameter int unsigned LEFT_WIDTH   = 8,
  parameter int unsigned RIGHT_WIDTH  = 8,
  parameter int unsigned FIFO_ADDR_SZ = 1,
  parameter int unsigned IN_WIDTH     = LEFT_WIDTH + RIGHT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [IN_WIDTH-1:0]    i_data,
  output logic                   o_left_valid,
  input  logic                   o_left_ready,
  output logic [LEFT_WIDTH-1:0]  o_left_data,
  output logic                   o_right_valid,
  input  logic                   o_right_ready,
  output logic [RIGHT_WIDTH-1:0] o_right_data
);
  logic left_full, right_full;
  logic push;

  // Ready depends only on registered FIFO counts, never on consumer ready.
  assign i_ready = !reset && !left_full && !right_full;
  assign push    = i_valid && i_ready;

  stream_split_side #(
    .W       (LEFT_WIDTH),
    .ADDR_SZ (FIFO_ADDR_SZ)
  ) u_left (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wdata   (i_data[IN_WIDTH-1:RIGHT_WIDTH]),
    .full    (left_full),
    .o_valid (o_left_valid),
    .o_ready (o_left_ready),
    .o_data  (o_left_data)
  );

  stream_split_side #(
    .W       (RIGHT_WIDTH),
    .ADDR_SZ (FIFO_ADDR_SZ)
  ) u_right (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wdata   (i_data[RIGHT_WIDTH-1:0]),
    .full    (right_full),
    .o_valid (o_right_valid),
    .o_ready (o_right_ready),
    .o_data  (o_right_data)
  );
endmodule

// File: tb/tb_stream_split.sv
// Testbench for stream_split (default build, DEPTH=2). A cycle-level
// reference model holds per-side queues of expected beats: beats are pushed
// when the model accepts input and popped when the model's consumer pops.
// Every cycle the DUT's ready/valid/data are compared against the model.

module tb_stream_split;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_data;
  logic        o_left_valid;
  logic        o_left_ready;
  logic [7:0]  o_left_data;
  logic        o_right_valid;
  logic        o_right_ready;
  logic [7:0]  o_right_data;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  ql[$];
  logic [7:0]  qr[$];

  always #5 clk = ~clk;

  stream_split #(
    .LEFT_WIDTH   (8),
    .RIGHT_WIDTH  (8),
    .FIFO_ADDR_SZ (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .i_ready       (i_ready),
    .i_data        (i_data),
    .o_left_valid  (o_left_valid),
    .o_left_ready  (o_left_ready),
    .o_left_data   (o_left_data),
    .o_right_valid (o_right_valid),
    .o_right_ready (o_right_ready),
    .o_right_data  (o_right_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compares the settled DUT outputs with the model, then advances one edge.
  task automatic cycle();
    logic m_ready, m_push, m_lpop, m_rpop;
    #1;
    if (reset) begin
      check("rst_i_ready", 32'(i_ready), 0);
      check("rst_l_valid", 32'(o_left_valid), 0);
      check("rst_r_valid", 32'(o_right_valid), 0);
      check("rst_l_data", 32'(o_left_data), 0);
      check("rst_r_data", 32'(o_right_data), 0);
      @(posedge clk);
      ql.delete();
      qr.delete();
    end else begin
      m_ready = (ql.size() < DEPTH) && (qr.size() < DEPTH);
      check("i_ready", 32'(i_ready), 32'(m_ready));
      check("l_valid", 32'(o_left_valid), 32'(ql.size() != 0));
      check("r_valid", 32'(o_right_valid), 32'(qr.size() != 0));
      if (ql.size() != 0) check("l_data", 32'(o_left_data), 32'(ql[0]));
      else                check("l_data_empty", 32'(o_left_data), 0);
      if (qr.size() != 0) check("r_data", 32'(o_right_data), 32'(qr[0]));
      else                check("r_data_empty", 32'(o_right_data), 0);
      m_push = i_valid && m_ready;
      m_lpop = (ql.size() != 0) && o_left_ready;
      m_rpop = (qr.size() != 0) && o_right_ready;
      @(posedge clk);
      if (m_lpop) void'(ql.pop_front());
      if (m_rpop) void'(qr.pop_front());
      if (m_push) begin
        ql.push_back(i_data[15:8]);
        qr.push_back(i_data[7:0]);
      end
    end
    #1;
  endtask

  task automatic drive(input logic rst, input logic v, input logic [15:0] d,
                       input logic lr, input logic rr);
    reset         = rst;
    i_valid       = v;
    i_data        = d;
    o_left_ready  = lr;
    o_right_ready = rr;
    cycle();
  endtask

  // Offers one beat, holding it until accepted or the cycle budget runs out.
  task automatic send(input logic [15:0] d, input logic lr, input logic rr);
    int unsigned n;
    logic acc;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      reset = 1'b0; i_valid = 1'b1; i_data = d;
      o_left_ready = lr; o_right_ready = rr;
      #1;
      acc = i_ready;
      cycle();
      n++;
    end
    check("send_timeout", 32'(acc), 1);
  endtask

  initial begin
    // Reset held two cycles with a beat offered.
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Full speed: one beat per cycle, both consumers ready.
    for (int k = 1; k <= 6; k++) begin
      logic [7:0] b;
      b = 8'(k);
      drive(1'b0, 1'b1, {b, b}, 1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Left stall: left fills, third beat waits for left to drain.
    drive(1'b0, 1'b1, 16'hA1B1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'hA2B2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'hA3B3, 1'b0, 1'b1);
    send(16'hA3B3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Mirror stall: right consumer held.
    drive(1'b0, 1'b1, 16'hC1D1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 16'hC2D2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'hC3D3, 1'b1, 1'b0);
    send(16'hC3D3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Skew: each side alternately stalled with random traffic.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      drive(1'b0, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Reset mid-stream with both FIFOs full, then a fresh beat.
    drive(1'b0, 1'b1, 16'h1122, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h3344, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h5566, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h5566, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0707, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    check("final_l_empty", 32'(ql.size()), 0);
    check("final_r_empty", 32'(qr.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
